// File: rtl/led_mode_controller.sv
// led_mode_controller: push-button LED mode sequencer.
// Synchronises and debounces one raw button, advances a 4-mode FSM on each
// debounced press, and drives the LED bank from a free-running tick divider.
module led_mode_controller #(
    parameter int unsigned TICK_DIVIDE     = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 3_000_000,
    parameter int unsigned NUM_LEDS        = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                button,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode,
    output logic                tick
);

    localparam int unsigned CW = $clog2(TICK_DIVIDE);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned IW = $clog2(NUM_LEDS);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CHASE = 2'd3
    } mode_t;

    logic          btn_meta;
    logic          btn_s;
    logic          deb;
    logic          deb_prev;
    logic [DW-1:0] deb_cnt;
    logic          press;
    logic [CW-1:0] tick_cnt;
    logic          wrap;
    logic          phase;
    logic [IW-1:0] idx;

    mode_t               state;
    mode_t               state_next;
    logic [NUM_LEDS-1:0] led_next;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= button;
            btn_s    <= btn_meta;
        end
    end

    // Debounce filter and registered rising-edge press pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            deb      <= 1'b0;
            deb_prev <= 1'b0;
            deb_cnt  <= '0;
            press    <= 1'b0;
        end else begin
            deb_prev <= deb;
            press    <= deb & ~deb_prev;
            if (btn_s != deb) begin
                if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb     <= btn_s;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign wrap = (tick_cnt == CW'(TICK_DIVIDE - 1));

    // Tick divider, blink phase and chase index; a press restarts all three
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
            phase    <= 1'b0;
            idx      <= '0;
        end else begin
            tick <= wrap;
            if (press) begin
                tick_cnt <= '0;
                phase    <= 1'b1;
                idx      <= '0;
            end else begin
                tick_cnt <= wrap ? '0 : tick_cnt + CW'(1);
                if (wrap) begin
                    phase <= ~phase;
                    idx   <= (idx == IW'(NUM_LEDS - 1)) ? '0 : idx + IW'(1);
                end
            end
        end
    end

    // Mode state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= MODE_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Mode sequencing: each press steps to the next mode, wrapping to OFF
    always_comb begin
        state_next = state;
        if (press) begin
            case (state)
                MODE_OFF:   state_next = MODE_SOLID;
                MODE_SOLID: state_next = MODE_BLINK;
                MODE_BLINK: state_next = MODE_CHASE;
                MODE_CHASE: state_next = MODE_OFF;
                default:    state_next = MODE_OFF;
            endcase
        end
    end

    // LED pattern for the current mode, phase and chase position
    always_comb begin
        led_next = '0;
        case (state)
            MODE_OFF:   led_next = '0;
            MODE_SOLID: led_next = '1;
            MODE_BLINK: led_next = {NUM_LEDS{phase}};
            MODE_CHASE: led_next = NUM_LEDS'(1) << idx;
            default:    led_next = '0;
        endcase
    end

    // Registered LED drive
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_led_mode_controller.sv
// Testbench for led_mode_controller: cycle-stamped scoreboard of expected
// mode/led/tick values, pushed as stimulus is driven and popped each cycle.
module tb_led_mode_controller;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int NL = 4;

    logic          clock;
    logic          reset;
    logic          button;
    logic [NL-1:0] led;
    logic [1:0]    mode;
    logic          tick;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          at;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    led_mode_controller #(
        .TICK_DIVIDE    (TD),
        .DEBOUNCE_CYCLES(DB),
        .NUM_LEDS       (NL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .button(button),
        .led   (led),
        .mode  (mode),
        .tick  (tick)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count completed rising edges
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, expv);
        end
    endtask

    // Insert keeping the queue ordered by cycle
    function automatic void push(input int at, input int kind, input logic [31:0] val);
        exp_t e;
        int   i;
        e.at   = at;
        e.kind = kind;
        e.val  = val;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endfunction

    // Expected LED pattern d cycles after a mode was entered (d >= 1)
    function automatic logic [31:0] led_for(input int m, input int d);
        int          k;
        logic [31:0] one;
        k   = (d - 1) / TD;
        one = 32'd1;
        case (m)
            0:       led_for = 32'h0;
            1:       led_for = 32'hF;
            2:       led_for = ((k % 2) == 0) ? 32'hF : 32'h0;
            default: led_for = one << (k % NL);
        endcase
    endfunction

    // Expectations from mode entry edge p through cycle last
    function automatic void push_window(input int p, input int m, input int last);
        for (int c = p; c <= last; c++) begin
            push(c, 0, 32'(m));
            if (c > p) begin
                push(c, 1, led_for(m, c - p));
                push(c, 2, ((c - p) % TD == 0) ? 32'd1 : 32'd0);
            end
        end
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    // Raise button at cycle c; mode must change at c+7 (DB+3 after first sample)
    task automatic press(input int c, input int hold, input int m, input int p_next);
        wait_cyc(c);
        push_window(c + 7, m, p_next - 1);
        button = 1'b1;
        wait_cyc(c + hold);
        button = 1'b0;
    endtask

    // Scoreboard: pop and compare everything due this cycle
    always @(negedge clock) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at != cyc) check("sched", 32'(e.at), 32'(cyc));
            case (e.kind)
                0:       check("mode", 32'(mode), e.val);
                1:       check("led", 32'(led), e.val);
                default: check("tick", 32'(tick), e.val);
            endcase
        end
    end

    initial begin
        reset  = 1'b1;
        button = 1'b0;

        // Reset state, then OFF with tick 4 cycles after release
        push(1, 0, 32'd0);
        push(1, 1, 32'd0);
        push(1, 2, 32'd0);
        push(2, 1, 32'd0);
        push(2, 2, 32'd0);
        push_window(2, 0, 36);
        wait_cyc(2);
        reset = 1'b0;

        // Two-cycle glitch must be filtered out
        wait_cyc(8);
        button = 1'b1;
        wait_cyc(10);
        button = 1'b0;

        // Long hold -> SOLID once; then BLINK, CHASE, OFF
        press(30, 20, 1, 67);
        press(60, 8, 2, 97);
        press(90, 8, 3, 127);
        press(120, 8, 0, 147);

        // Presses landing on the divider wrap: tick still pulses, press wins
        press(140, 8, 1, 167);
        push(167, 2, 32'd1);
        press(160, 8, 2, 187);
        push(187, 2, 32'd1);
        press(180, 8, 3, 206);

        // Reset in the middle of CHASE
        wait_cyc(205);
        push(206, 0, 32'd0);
        push(206, 1, 32'd0);
        push(206, 2, 32'd0);
        push(207, 1, 32'd0);
        push(207, 2, 32'd0);
        push_window(207, 0, 230);
        reset = 1'b1;
        wait_cyc(207);
        reset = 1'b0;

        wait_cyc(232);
        check("drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
